spi_txn_arbiter: RTL and testbench

SPI_TXN_ARBITER -- requirements
Module: spi_txn_arbiter

---
 rtl/spi_txn_arbiter.sv | 118 +++++++++++
 tb/tb_spi_txn_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter: round-robin arbiter that sequences requester transactions onto one SPI master engine
module spi_txn_arbiter #(
  parameter int NREQ    = 4,
  parameter int GAP_CYC = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req,
  input  logic [7*NREQ-1:0] req_addr,
  input  logic [NREQ-1:0]   req_rw,
  input  logic [8*NREQ-1:0] req_wdata,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic              err,
  output logic [7:0]        rdata,
  output logic              cs,
  output logic [6:0]        m_addr,
  output logic              m_rw,
  output logic [7:0]        m_wdata,
  input  logic              sclk_pos,
  input  logic [7:0]        m_rdata,
  input  logic              m_rvalid
);
  localparam int PW = $clog2(NREQ);
  typedef enum logic [2:0] {IDLE, ARB, SELECT, XFER, GAP} state_t;
  state_t state, nxt;
  logic run, pend, hit, last_edge, tmo, gap_exit;
  logic [PW-1:0] rr_ptr, win;
  logic [4:0] ecnt;
  logic [7:0] tcnt;
  logic [3:0] gcnt;
  assign cs        = !(state == SELECT || state == XFER);
  assign last_edge = state == XFER && sclk_pos && ecnt == 5'd15;
  assign tmo       = state == XFER && !sclk_pos && tcnt == 8'(TIMEOUT - 1);
  assign gap_exit  = state == GAP && gcnt >= 4'(GAP_CYC - 1) && !pend;
  // Scan from farthest to nearest so the nearest requester after rr_ptr wins
  always_comb begin
    win = rr_ptr;
    hit = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[(int'(rr_ptr) + k) % NREQ]) begin
        win = PW'((int'(rr_ptr) + k) % NREQ);
        hit = 1'b1;
      end
    end
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = |req ? ARB : IDLE;
      ARB:     nxt = hit ? SELECT : IDLE;
      SELECT:  nxt = XFER;
      XFER:    nxt = (last_edge || tmo) ? GAP : XFER;
      GAP:     nxt = gap_exit ? (|req ? ARB : IDLE) : GAP;
      default: nxt = IDLE;
    endcase
    if (!run) nxt = state;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= nxt;
  end
  // run delays the first state change after reset release by one extra edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run     <= 1'b0;
      pend    <= 1'b0;
      grant   <= '0;
      done    <= '0;
      err     <= 1'b0;
      rdata   <= '0;
      m_addr  <= '0;
      m_rw    <= 1'b0;
      m_wdata <= '0;
      rr_ptr  <= PW'(NREQ - 1);
      ecnt    <= '0;
      tcnt    <= '0;
      gcnt    <= '0;
    end else begin
      run  <= 1'b1;
      done <= '0;
      err  <= 1'b0;
      gcnt <= state == GAP ? gcnt + 4'd1 : '0;
      if (state == ARB && hit) begin
        grant   <= NREQ'(1) << win;
        rr_ptr  <= win;
        m_addr  <= req_addr[7*win +: 7];
        m_rw    <= req_rw[win];
        m_wdata <= req_wdata[8*win +: 8];
      end
      if (state == SELECT) begin
        ecnt <= '0;
        tcnt <= '0;
      end
      if (state == XFER) begin
        ecnt <= sclk_pos ? ecnt + 5'd1 : ecnt;
        tcnt <= sclk_pos ? '0 : tcnt + 8'd1;
      end
      if (last_edge) begin
        pend <= m_rw;
        done <= m_rw ? '0 : grant;
      end
      if (tmo) begin
        done <= grant;
        err  <= 1'b1;
      end
      // Read completion waits for the engine strobe, giving up two cycles into GAP
      if (state == GAP && pend && (m_rvalid || gcnt == 4'd1)) begin
        pend  <= 1'b0;
        done  <= grant;
        err   <= !m_rvalid;
        rdata <= m_rvalid ? m_rdata : rdata;
      end
      if (gap_exit) grant <= '0;
    end
  end
endmodule

// File: tb/tb_spi_txn_arbiter.sv
// tb_spi_txn_arbiter: randomized bench for spi_txn_arbiter against a transaction-level model
module tb_spi_txn_arbiter;
  localparam int NREQ = 4, GAP_CYC = 4, TIMEOUT = 255;
  logic clk = 1'b0, reset_n = 1'b0, err, cs, m_rw, sclk_pos, m_rvalid;
  logic [NREQ-1:0] req, req_rw, grant, done;
  logic [7*NREQ-1:0] req_addr;
  logic [8*NREQ-1:0] req_wdata;
  logic [7:0] rdata, m_wdata, m_rdata, model_rdata;
  logic [6:0] m_addr;
  int checks = 0, errors = 0, model_rr = NREQ - 1;

  spi_txn_arbiter #(.NREQ(NREQ), .GAP_CYC(GAP_CYC), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_addr(req_addr), .req_rw(req_rw),
    .req_wdata(req_wdata), .grant(grant), .done(done), .err(err), .rdata(rdata), .cs(cs),
    .m_addr(m_addr), .m_rw(m_rw), .m_wdata(m_wdata), .sclk_pos(sclk_pos),
    .m_rdata(m_rdata), .m_rvalid(m_rvalid)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [NREQ-1:0] r);
    for (int k = 1; k <= NREQ; k++) if (r[(model_rr + k) % NREQ]) return (model_rr + k) % NREQ;
    return 0;
  endfunction

  task automatic randomize_fields();
    for (int i = 0; i < NREQ; i++) begin
      req_addr[7*i +: 7]  = 7'($urandom);
      req_wdata[8*i +: 8] = 8'($urandom);
      req_rw[i]           = 1'($urandom);
    end
  endtask

  // Plays the SPI engine for one whole transaction of the model's predicted winner
  task automatic serve(input bit keep, input bit drop, input logic [NREQ-1:0] arrive,
                       input int rv_at, input logic [7:0] rbyte, output int hi);
    int x, dc;
    bit rd, bad, xerr;
    logic [NREQ-1:0] oh;
    x = pick(req);
    model_rr = x;
    oh = NREQ'(1) << x;
    rd = req_rw[x];
    hi = 0;
    bad = 0;
    while (cs !== 1'b0 && hi < 40) begin
      hi++;
      tick();
    end
    checks++;
    if (cs !== 1'b0) begin
      errors++;
      $display("FAIL cs_wait: cs=%b after %0d cycles, required 0", cs, hi);
      return;
    end
    checks++;
    if (grant !== oh || m_addr !== req_addr[7*x +: 7] || m_rw !== rd || m_wdata !== req_wdata[8*x +: 8]) begin
      errors++;
      $display("FAIL select: grant=%b addr=%h rw=%b wdata=%h, required %b %h %b %h",
               grant, m_addr, m_rw, m_wdata, oh, req_addr[7*x +: 7], rd, req_wdata[8*x +: 8]);
    end
    sclk_pos = 1'($urandom);
    tick();
    sclk_pos = 1'b0;
    for (int e = 1; e <= 16; e++) begin
      repeat ($urandom_range(0, 2)) begin
        tick();
        if (cs !== 1'b0 || done !== '0 || err !== 1'b0) bad = 1;
      end
      if (e == 4) req = (drop ? req & ~oh : req) | arrive;
      m_rvalid = (e == 10);
      m_rdata = 8'($urandom);
      sclk_pos = 1'b1;
      tick();
      sclk_pos = 1'b0;
      m_rvalid = 1'b0;
      if (e < 16 && (cs !== 1'b0 || done !== '0 || err !== 1'b0)) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL xfer: cs/done/err disturbed during 16 edges, required cs=0 done=0 err=0");
    end
    dc = !rd ? 0 : (rv_at == 0 ? 1 : 2);
    for (int g = 0; g < 3; g++) begin
      if (g == dc && rd && rv_at < 2) model_rdata = rbyte;
      xerr = g == dc && rd && rv_at == 2;
      checks++;
      if (cs !== 1'b1 || done !== (g == dc ? oh : '0) || err !== xerr || rdata !== model_rdata) begin
        errors++;
        $display("FAIL gap%0d: cs=%b done=%b err=%b rdata=%h, required cs=1 done=%b err=%b rdata=%h",
                 g, cs, done, err, rdata, (g == dc ? oh : '0), xerr, model_rdata);
      end
      if (g == dc && !keep) req[x] = 1'b0;
      m_rvalid = rd && g == rv_at;
      m_rdata = m_rvalid ? rbyte : 8'($urandom);
      if (g < 2) tick();
      m_rvalid = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) tick();
    checks++;
    if (cs !== 1'b1 || grant !== '0 || done !== '0 || err !== 1'b0 || rdata !== 8'h00) begin
      errors++;
      $display("FAIL reset: cs=%b grant=%b done=%b err=%b rdata=%h, required 1 0 0 0 00", cs, grant, done, err, rdata);
    end
    reset_n = 1'b1;
    repeat (3) tick();
    checks++;
    if (cs !== 1'b1 || grant !== '0) begin
      errors++;
      $display("FAIL idle: cs=%b grant=%b, required cs=1 grant=0", cs, grant);
    end
  endtask

  task automatic test_write();
    int hi;
    randomize_fields();
    req_addr[6:0] = 7'h15;
    req_rw[0] = 1'b0;
    req_wdata[7:0] = 8'hA5;
    req = 4'b0001;
    serve(0, 0, '0, 2, 8'h00, hi);
  endtask

  task automatic test_read();
    int hi;
    randomize_fields();
    req_rw[2] = 1'b1;
    req = 4'b0100;
    serve(0, 0, '0, 0, 8'h3C, hi);
  endtask

  task automatic test_read_missing();
    int hi;
    randomize_fields();
    req_rw[0] = 1'b1;
    req = 4'b0001;
    serve(0, 0, '0, 2, 8'h77, hi);
  endtask

  task automatic test_preempt();
    int hi;
    randomize_fields();
    req = 4'b0001;
    serve(0, 1, 4'b0010, $urandom_range(0, 2), 8'($urandom), hi);
    serve(0, 0, '0, $urandom_range(0, 2), 8'($urandom), hi);
  endtask

  task automatic test_timeout();
    int n, x;
    logic [NREQ-1:0] oh;
    randomize_fields();
    req = NREQ'(1) << $urandom_range(0, NREQ - 1);
    x = pick(req);
    model_rr = x;
    oh = NREQ'(1) << x;
    n = 0;
    while (cs !== 1'b0 && n < 40) begin
      n++;
      tick();
    end
    tick();
    repeat (5) begin
      sclk_pos = 1'b1;
      tick();
    end
    sclk_pos = 1'b0;
    n = 0;
    while (cs === 1'b0 && n < 400) begin
      n++;
      tick();
    end
    checks++;
    if (n != TIMEOUT || done !== oh || err !== 1'b1 || rdata !== model_rdata) begin
      errors++;
      $display("FAIL timeout: cs low %0d cycles done=%b err=%b rdata=%h, required %0d %b 1 %h",
               n, done, err, rdata, TIMEOUT, oh, model_rdata);
    end
    req = '0;
    tick();
    checks++;
    if (done !== '0 || err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse: done=%b err=%b one cycle later, required 0 0", done, err);
    end
    repeat (6) tick();
  endtask

  task automatic test_reset_mid();
    int n, hi;
    bit bad;
    randomize_fields();
    req_rw[0] = 1'b0;
    req = 4'b0001;
    n = 0;
    while (cs !== 1'b0 && n < 40) begin
      n++;
      tick();
    end
    tick();
    repeat (10) begin
      sclk_pos = 1'b1;
      tick();
    end
    sclk_pos = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (cs !== 1'b1 || grant !== '0 || done !== '0) begin
      errors++;
      $display("FAIL async_reset: cs=%b grant=%b done=%b, required 1 0 0", cs, grant, done);
    end
    bad = 0;
    repeat (3) begin
      tick();
      if (done !== '0 || err !== 1'b0 || cs !== 1'b1) bad = 1;
    end
    checks++;
    if (bad || rdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_hold: done/err/cs disturbed or rdata=%h, required done=0 rdata=00", rdata);
    end
    model_rr = NREQ - 1;
    model_rdata = 8'h00;
    req = 4'b0010;
    reset_n = 1'b1;
    serve(0, 0, '0, $urandom_range(0, 2), 8'($urandom), hi);
    checks++;
    if (hi != 3) begin
      errors++;
      $display("FAIL release_latency: cs fell %0d cycles after release, required 3", hi);
    end
  endtask

  task automatic test_back_to_back();
    int hi;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    model_rr = NREQ - 1;
    model_rdata = 8'h00;
    randomize_fields();
    req = '1;
    for (int t = 0; t < 5; t++) begin
      serve(1, 0, '0, $urandom_range(0, 2), 8'($urandom), hi);
      if (t > 0) begin
        checks++;
        if (3 + hi < GAP_CYC) begin
          errors++;
          $display("FAIL gap_len: cs high %0d cycles between transactions, required >= %0d", 3 + hi, GAP_CYC);
        end
      end
    end
    req = '0;
    repeat (4) tick();
  endtask

  task automatic test_random();
    int hi;
    for (int t = 0; t < 14; t++) begin
      randomize_fields();
      do req = NREQ'($urandom); while (req == '0);
      serve(0, 1'($urandom), '0, $urandom_range(0, 2), 8'($urandom), hi);
      if ($urandom_range(0, 2) == 0) begin
        req = '0;
        repeat (6) tick();
      end
    end
  endtask

  initial begin
    req = '0;
    req_addr = '0;
    req_rw = '0;
    req_wdata = '0;
    sclk_pos = 1'b0;
    m_rvalid = 1'b0;
    m_rdata = 8'h00;
    model_rdata = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_read_missing();
    test_preempt();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
